score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
- Match-sequencing controller for the pong score path.
- Owns the player and enemy score counters; the counter values drive the score-display block's player/enemy score inputs.
- Sequences serve, play, point and game-over phases from goal events and the per-frame tick.
- Gates ball motion and requests ball re-centering on every serve.

Parameters:
- M_SCORE_W, 4, width of each score counter; must equal the score-display input width.
- WIN_SCORE, 9, score that ends the match; legal range 1..9 (single displayed digit).
- SERVE_FRAMES, 60, frame ticks spent in serve wait before the ball moves; must be >= 1.
- RESTART_FRAMES, 180, frame ticks before automatic restart; used only with the optional feature; must be >= 1.

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, asynchronous active-high reset.
- frame_tick_i, input, 1, one-cycle pulse per video frame.
- start_i, input, 1, level; start/restart request (debounced upstream).
- player_goal_i, input, 1, one-cycle pulse; ball passed the enemy paddle, player scores.
- enemy_goal_i, input, 1, one-cycle pulse; ball passed the player paddle, enemy scores.
- player_score_o, output, M_SCORE_W, player score counter.
- enemy_score_o, output, M_SCORE_W, enemy score counter.
- serve_o, output, 1, one-cycle pulse; re-center the ball.
- ball_en_o, output, 1, ball may move.
- game_over_o, output, 1, match finished.
- winner_o, output, 1, valid while game_over_o = 1; 1 = player won, 0 = enemy won.

Behaviour:
- Timing model: all outputs registered (Moore); a condition sampled at edge N produces the new state and outputs after edge N.
- Reset (async assert): state IDLE; both scores 0; serve_o, ball_en_o, game_over_o and winner_o 0; frame counter 0. Reset asserted mid-match aborts immediately with no partial update.
- Deassertion is synchronized upstream; no internal synchronizer is required.
- States: IDLE, SERVE_WAIT, PLAY, GAME_OVER.
- IDLE:
  - Outputs idle; scores held at 0.
  - start_i = 1 -> SERVE_WAIT; counter loads SERVE_FRAMES; serve_o = 1 for the first SERVE_WAIT cycle only.
- SERVE_WAIT:
  - ball_en_o = 0.
  - Each frame_tick_i decrements the counter.
  - Tick while counter == 1 -> PLAY. Exactly SERVE_FRAMES ticks are consumed.
  - Goal pulses and start_i are ignored.
- PLAY:
  - ball_en_o = 1.
  - player_goal_i alone: player_score += 1.
  - enemy_goal_i alone: enemy_score += 1.
  - Both in the same cycle: no score change; re-serve (-> SERVE_WAIT with a serve_o pulse).
  - After a single goal: if the incremented score == WIN_SCORE -> GAME_OVER, with winner_o set to the scorer. Otherwise -> SERVE_WAIT with counter reloaded and serve_o pulsed.
  - Score update and state change occur on the same edge.
  - frame_tick_i coinciding with a goal has no effect.
- GAME_OVER:
  - ball_en_o = 0; game_over_o = 1; scores and winner_o held.
  - start_i = 1 -> clear both scores, clear game_over_o -> SERVE_WAIT with a serve_o pulse.
  - Goals are ignored.
- Arithmetic: scores never exceed WIN_SCORE, so there is no wrap or saturation logic. Compare at M_SCORE_W width.
- start_i held high through game over restarts immediately when GAME_OVER is entered on the next cycle. This is intended (level semantics).
- serve_o is never asserted in consecutive cycles.

Optional Feature:
- Macro: SCORE_CTRL_AUTO_RESTART_EN.
- Defined:
  - On entry to GAME_OVER, the counter loads RESTART_FRAMES.
  - Each frame_tick_i decrements it; the tick at counter == 1 restarts exactly as start_i does (scores cleared, SERVE_WAIT, serve_o pulse).
  - start_i still restarts early.
- Not defined: GAME_OVER is left only via start_i or reset, and RESTART_FRAMES is unused.

Test Plan:
- Reset, then start_i for 1 cycle with SERVE_FRAMES = 3 -> serve_o pulses exactly once; ball_en_o rises the cycle after the 3rd frame_tick_i; scores 0/0.
- In PLAY, player_goal_i pulse -> next cycle player_score_o = 1, enemy 0, serve_o = 1, ball_en_o = 0; ball_en_o returns after 3 ticks.
- player_goal_i and enemy_goal_i in the same cycle at score 2/2 -> scores stay 2/2; serve_o pulses; back in SERVE_WAIT.
- WIN_SCORE = 3; enemy scores 3 times -> enemy_score_o = 3, game_over_o = 1, winner_o = 0, ball_en_o = 0; further goals ignored; start_i -> scores 0/0, serve_o pulse.
- rst_i asserted asynchronously mid-PLAY at 4/5 -> outputs 0 immediately without a clock edge; IDLE after release.
- With SCORE_CTRL_AUTO_RESTART_EN and RESTART_FRAMES = 2, player wins -> after 2 frame ticks with no start_i, scores 0/0 and serve_o pulses. Without the macro -> GAME_OVER held indefinitely.

Source files
------------

// File: rtl/score_ctrl.sv
// ============================================================================
// Module   : score_ctrl
// Purpose  : Pong match sequencer; owns both score counters and steps through
//            serve / play / game-over from goal pulses and the frame tick.
// Options  : SCORE_CTRL_AUTO_RESTART_EN - leave GAME_OVER after RESTART_FRAMES
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_ctrl #(
    parameter int M_SCORE_W      = 4,
    parameter int WIN_SCORE      = 9,
    parameter int SERVE_FRAMES   = 60,
    parameter int RESTART_FRAMES = 180
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 frame_tick_i,
    input  logic                 start_i,
    input  logic                 player_goal_i,
    input  logic                 enemy_goal_i,
    output logic [M_SCORE_W-1:0] player_score_o,
    output logic [M_SCORE_W-1:0] enemy_score_o,
    output logic                 serve_o,
    output logic                 ball_en_o,
    output logic                 game_over_o,
    output logic                 winner_o
);

    // One shared frame counter covers both the serve wait and the restart wait.
    localparam int c_cnt_max = (SERVE_FRAMES > RESTART_FRAMES) ? SERVE_FRAMES : RESTART_FRAMES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0]   c_serve_load = c_cnt_w'(SERVE_FRAMES);
    localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);
    localparam logic [M_SCORE_W-1:0] c_win        = M_SCORE_W'(WIN_SCORE);
    localparam logic [M_SCORE_W-1:0] c_score_one  = M_SCORE_W'(1);
    localparam logic [M_SCORE_W-1:0] c_score_zero = '0;
`ifdef SCORE_CTRL_AUTO_RESTART_EN
    localparam logic [c_cnt_w-1:0]   c_restart_load = c_cnt_w'(RESTART_FRAMES);
`endif

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVE_WAIT = 2'd1,
        ST_PLAY       = 2'd2,
        ST_GAME_OVER  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [M_SCORE_W-1:0]   r_player;
    logic [M_SCORE_W-1:0]   w_player_nxt;
    logic [M_SCORE_W-1:0]   r_enemy;
    logic [M_SCORE_W-1:0]   w_enemy_nxt;
    logic                   r_serve;
    logic                   w_serve_nxt;
    logic                   r_winner;
    logic                   w_winner_nxt;
    logic                   r_ball_en;
    logic                   r_game_over;
    logic [M_SCORE_W-1:0]   w_player_inc;
    logic [M_SCORE_W-1:0]   w_enemy_inc;
    logic                   w_restart;

    assign w_player_inc = r_player + c_score_one;
    assign w_enemy_inc  = r_enemy + c_score_one;

`ifdef SCORE_CTRL_AUTO_RESTART_EN
    assign w_restart = start_i | (frame_tick_i & (r_cnt == c_cnt_one));
`else
    assign w_restart = start_i;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_player_nxt = r_player;
        w_enemy_nxt  = r_enemy;
        w_serve_nxt  = 1'b0;
        w_winner_nxt = r_winner;

        case (r_state)
            ST_IDLE: begin
                w_player_nxt = c_score_zero;
                w_enemy_nxt  = c_score_zero;
                if (start_i) begin
                    w_state_nxt = ST_SERVE_WAIT;
                    w_cnt_nxt   = c_serve_load;
                    w_serve_nxt = 1'b1;
                end
            end

            ST_SERVE_WAIT: begin
                if (frame_tick_i) begin
                    if (r_cnt == c_cnt_one) begin
                        w_state_nxt = ST_PLAY;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
            end

            ST_PLAY: begin
                // Simultaneous goals cancel out and simply re-serve.
                if (player_goal_i && enemy_goal_i) begin
                    w_state_nxt = ST_SERVE_WAIT;
                    w_cnt_nxt   = c_serve_load;
                    w_serve_nxt = 1'b1;
                end else if (player_goal_i || enemy_goal_i) begin
                    if (player_goal_i) begin
                        w_player_nxt = w_player_inc;
                    end else begin
                        w_enemy_nxt = w_enemy_inc;
                    end
                    if ((player_goal_i && (w_player_inc == c_win)) ||
                        (enemy_goal_i && (w_enemy_inc == c_win))) begin
                        w_state_nxt  = ST_GAME_OVER;
                        w_winner_nxt = player_goal_i;
`ifdef SCORE_CTRL_AUTO_RESTART_EN
                        w_cnt_nxt    = c_restart_load;
`endif
                    end else begin
                        w_state_nxt = ST_SERVE_WAIT;
                        w_cnt_nxt   = c_serve_load;
                        w_serve_nxt = 1'b1;
                    end
                end
            end

            ST_GAME_OVER: begin
                if (w_restart) begin
                    w_state_nxt  = ST_SERVE_WAIT;
                    w_cnt_nxt    = c_serve_load;
                    w_serve_nxt  = 1'b1;
                    w_player_nxt = c_score_zero;
                    w_enemy_nxt  = c_score_zero;
                    w_winner_nxt = 1'b0;
`ifdef SCORE_CTRL_AUTO_RESTART_EN
                end else if (frame_tick_i) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
`endif
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ball-enable and game-over are registered from the next state so every
    // output changes on the same edge as the state itself.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_player    <= '0;
            r_enemy     <= '0;
            r_serve     <= 1'b0;
            r_winner    <= 1'b0;
            r_ball_en   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_player    <= w_player_nxt;
            r_enemy     <= w_enemy_nxt;
            r_serve     <= w_serve_nxt;
            r_winner    <= w_winner_nxt;
            r_ball_en   <= (w_state_nxt == ST_PLAY);
            r_game_over <= (w_state_nxt == ST_GAME_OVER);
        end
    end

    assign player_score_o = r_player;
    assign enemy_score_o  = r_enemy;
    assign serve_o        = r_serve;
    assign ball_en_o      = r_ball_en;
    assign game_over_o    = r_game_over;
    assign winner_o       = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_score_ctrl.sv
// ============================================================================
// Module   : tb_score_ctrl
// Purpose  : Directed self-checking bench for score_ctrl (WIN 3 and WIN 9 copies).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pg = 1'b0;
    logic       eg = 1'b0;

    logic [3:0] a_player, a_enemy, b_player, b_enemy;
    logic       a_serve, a_ball, a_over, a_win;
    logic       b_serve, b_ball, b_over, b_win;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    score_ctrl #(.M_SCORE_W(4), .WIN_SCORE(3), .SERVE_FRAMES(3), .RESTART_FRAMES(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick), .start_i(start),
        .player_goal_i(pg), .enemy_goal_i(eg),
        .player_score_o(a_player), .enemy_score_o(a_enemy), .serve_o(a_serve),
        .ball_en_o(a_ball), .game_over_o(a_over), .winner_o(a_win)
    );

    // Higher win score so a 4/5 mid-match state is reachable.
    score_ctrl #(.M_SCORE_W(4), .WIN_SCORE(9), .SERVE_FRAMES(3), .RESTART_FRAMES(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick), .start_i(start),
        .player_goal_i(pg), .enemy_goal_i(eg),
        .player_score_o(b_player), .enemy_score_o(b_enemy), .serve_o(b_serve),
        .ball_en_o(b_ball), .game_over_o(b_over), .winner_o(b_win)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; pg = 1'b0; eg = 1'b0; frame_tick = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic serve_out();
        repeat (3) tick();
    endtask

    task automatic go_play();
        start = 1'b1;
        step();
        start = 1'b0;
        serve_out();
    endtask

    task automatic pgoal();
        pg = 1'b1;
        step();
        pg = 1'b0;
    endtask

    task automatic egoal();
        eg = 1'b1;
        step();
        eg = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (a_player !== 4'd0) begin n_err++; $display("FAIL rst_player: got %0d expected 0", a_player); end
        n_vec++; if (a_enemy !== 4'd0) begin n_err++; $display("FAIL rst_enemy: got %0d expected 0", a_enemy); end
        n_vec++; if ({a_serve, a_ball, a_over, a_win} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b expected 0000", {a_serve, a_ball, a_over, a_win}); end
        repeat (4) tick();
        n_vec++; if (a_ball !== 1'b0 || a_serve !== 1'b0) begin n_err++; $display("FAIL idle_no_start: got ball=%b serve=%b expected 0 0", a_ball, a_serve); end
    endtask

    task automatic test_serve();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++; if (a_serve !== 1'b1) begin n_err++; $display("FAIL serve_first: got %b expected 1", a_serve); end
        n_vec++; if (a_ball !== 1'b0) begin n_err++; $display("FAIL serve_ball: got %b expected 0", a_ball); end
        step();
        n_vec++; if (a_serve !== 1'b0) begin n_err++; $display("FAIL serve_once: got %b expected 0", a_serve); end
        tick();
        tick();
        n_vec++; if (a_ball !== 1'b0 || a_serve !== 1'b0) begin n_err++; $display("FAIL serve_2ticks: got ball=%b serve=%b expected 0 0", a_ball, a_serve); end
        tick();
        n_vec++; if (a_ball !== 1'b1) begin n_err++; $display("FAIL serve_3ticks: got %b expected 1", a_ball); end
        n_vec++; if ({a_player, a_enemy} !== 8'h00) begin n_err++; $display("FAIL serve_scores: got %0d/%0d expected 0/0", a_player, a_enemy); end
    endtask

    task automatic test_player_goal();
        do_reset();
        go_play();
        frame_tick = 1'b1;
        pgoal();
        frame_tick = 1'b0;
        n_vec++; if (a_player !== 4'd1 || a_enemy !== 4'd0) begin n_err++; $display("FAIL goal_scores: got %0d/%0d expected 1/0", a_player, a_enemy); end
        n_vec++; if (a_serve !== 1'b1 || a_ball !== 1'b0) begin n_err++; $display("FAIL goal_serve: got serve=%b ball=%b expected 1 0", a_serve, a_ball); end
        tick();
        tick();
        n_vec++; if (a_ball !== 1'b0) begin n_err++; $display("FAIL goal_tick_ignored: got %b expected 0", a_ball); end
        tick();
        n_vec++; if (a_ball !== 1'b1) begin n_err++; $display("FAIL goal_reserve: got %b expected 1", a_ball); end
    endtask

    task automatic test_double_goal();
        do_reset();
        go_play();
        pgoal(); serve_out();
        egoal(); serve_out();
        pgoal(); serve_out();
        egoal(); serve_out();
        n_vec++; if (a_player !== 4'd2 || a_enemy !== 4'd2 || a_ball !== 1'b1) begin n_err++; $display("FAIL dbl_pre: got %0d/%0d ball=%b expected 2/2 1", a_player, a_enemy, a_ball); end
        pg = 1'b1; eg = 1'b1;
        step();
        pg = 1'b0; eg = 1'b0;
        n_vec++; if (a_player !== 4'd2 || a_enemy !== 4'd2) begin n_err++; $display("FAIL dbl_scores: got %0d/%0d expected 2/2", a_player, a_enemy); end
        n_vec++; if (a_serve !== 1'b1 || a_ball !== 1'b0 || a_over !== 1'b0) begin n_err++; $display("FAIL dbl_serve: got serve=%b ball=%b over=%b expected 1 0 0", a_serve, a_ball, a_over); end
        step();
        n_vec++; if (a_serve !== 1'b0) begin n_err++; $display("FAIL dbl_serve_once: got %b expected 0", a_serve); end
        serve_out();
        n_vec++; if (a_ball !== 1'b1) begin n_err++; $display("FAIL dbl_replay: got %b expected 1", a_ball); end
    endtask

    task automatic test_enemy_win();
        do_reset();
        go_play();
        egoal(); serve_out();
        egoal(); serve_out();
        egoal();
        n_vec++; if (a_enemy !== 4'd3 || a_player !== 4'd0) begin n_err++; $display("FAIL win_scores: got %0d/%0d expected 0/3", a_player, a_enemy); end
        n_vec++; if ({a_over, a_win, a_ball, a_serve} !== 4'b1000) begin n_err++; $display("FAIL win_flags: got %b expected 1000", {a_over, a_win, a_ball, a_serve}); end
        pgoal();
        egoal();
        step();
        n_vec++; if (a_player !== 4'd0 || a_enemy !== 4'd3 || a_over !== 1'b1) begin n_err++; $display("FAIL win_goals_ignored: got %0d/%0d over=%b expected 0/3 1", a_player, a_enemy, a_over); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++; if (a_player !== 4'd0 || a_enemy !== 4'd0) begin n_err++; $display("FAIL restart_scores: got %0d/%0d expected 0/0", a_player, a_enemy); end
        n_vec++; if (a_serve !== 1'b1 || a_over !== 1'b0 || a_ball !== 1'b0) begin n_err++; $display("FAIL restart_flags: got serve=%b over=%b ball=%b expected 1 0 0", a_serve, a_over, a_ball); end
    endtask

    task automatic test_async_reset();
        do_reset();
        go_play();
        pgoal(); serve_out();
        egoal(); serve_out();
        pgoal(); serve_out();
        egoal(); serve_out();
        pgoal(); serve_out();
        egoal(); serve_out();
        pgoal(); serve_out();
        egoal(); serve_out();
        egoal(); serve_out();
        n_vec++; if (b_player !== 4'd4 || b_enemy !== 4'd5 || b_ball !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %0d/%0d ball=%b expected 4/5 1", b_player, b_enemy, b_ball); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (b_player !== 4'd0 || b_enemy !== 4'd0) begin n_err++; $display("FAIL ar_scores: got %0d/%0d expected 0/0", b_player, b_enemy); end
        n_vec++; if ({b_serve, b_ball, b_over, b_win} !== 4'b0000) begin n_err++; $display("FAIL ar_flags: got %b expected 0000", {b_serve, b_ball, b_over, b_win}); end
        step();
        rst = 1'b0;
        step();
        repeat (4) tick();
        n_vec++; if (b_ball !== 1'b0 || b_serve !== 1'b0 || a_over !== 1'b0) begin n_err++; $display("FAIL ar_idle: got ball=%b serve=%b over=%b expected 0 0 0", b_ball, b_serve, a_over); end
    endtask

    task automatic test_game_over_exit();
        do_reset();
        go_play();
        pgoal(); serve_out();
        pgoal(); serve_out();
        pgoal();
        n_vec++; if (a_over !== 1'b1 || a_win !== 1'b1 || a_player !== 4'd3) begin n_err++; $display("FAIL pwin: got over=%b win=%b player=%0d expected 1 1 3", a_over, a_win, a_player); end
        tick();
        n_vec++; if (a_over !== 1'b1 || a_serve !== 1'b0) begin n_err++; $display("FAIL go_tick1: got over=%b serve=%b expected 1 0", a_over, a_serve); end
        tick();
`ifdef SCORE_CTRL_AUTO_RESTART_EN
        n_vec++; if (a_serve !== 1'b1 || a_over !== 1'b0) begin n_err++; $display("FAIL auto_restart: got serve=%b over=%b expected 1 0", a_serve, a_over); end
        n_vec++; if (a_player !== 4'd0 || a_enemy !== 4'd0) begin n_err++; $display("FAIL auto_scores: got %0d/%0d expected 0/0", a_player, a_enemy); end
`else
        repeat (5) tick();
        n_vec++; if (a_over !== 1'b1 || a_serve !== 1'b0) begin n_err++; $display("FAIL go_hold: got over=%b serve=%b expected 1 0", a_over, a_serve); end
        n_vec++; if (a_player !== 4'd3 || a_win !== 1'b1) begin n_err++; $display("FAIL go_hold_score: got player=%0d win=%b expected 3 1", a_player, a_win); end
`endif
    endtask

    initial begin
        test_reset();
        test_serve();
        test_player_goal();
        test_double_goal();
        test_enemy_win();
        test_async_reset();
        test_game_over_exit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
